// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX hazard scoreboard: entry phase encoding and common widths.
package cpu_pkg;

  localparam int LAT_W       = 4;
  localparam int FWD_REGFILE = 0;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EXEC = 2'd1,
    PH_POST = 2'd2
  } phase_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks the single newest in-flight producer of one architectural register.
module sb_entry
  import cpu_pkg::*;
#(
  parameter int POST_STAGES = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  input  logic             is_load_in,
  output phase_t           phase,
  output logic [LAT_W-1:0] cnt,
  output logic             is_load
);

  phase_t           phase_q, phase_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
    end
  end

  // A new issue always takes the entry, even if the old producer commits this very cycle.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    if (enable) begin
      if (load) begin
        phase_d   = PH_EXEC;
        cnt_d     = lat;
        is_load_d = is_load_in;
      end else begin
        case (phase_q)
          PH_IDLE: ;
          PH_EXEC: begin
            if (cnt_q > LAT_W'(1)) begin
              cnt_d = cnt_q - LAT_W'(1);
            end else begin
              phase_d = PH_POST;
              cnt_d   = LAT_W'(1);
            end
          end
          PH_POST: begin
            if (cnt_q < LAT_W'(POST_STAGES)) begin
              cnt_d = cnt_q + LAT_W'(1);
            end else begin
              phase_d   = PH_IDLE;
              cnt_d     = '0;
              is_load_d = 1'b0;
            end
          end
          default: begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign phase   = phase_q;
  assign cnt     = cnt_q;
  assign is_load = is_load_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard unit: per-register scoreboard producing the ID stall and EX operand forward selects.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NREG        = 32,
  parameter  int REG_AW      = 5,
  parameter  int MAX_LAT     = 4,
  parameter  int POST_STAGES = 2,
  parameter  int LOAD_STAGE  = 2,
  parameter  int FWD_EN      = 1,
  localparam int SEL_W       = $clog2(POST_STAGES + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [LAT_W-1:0]  id_lat,
  output logic              stall,
  output logic              ex_busy,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b
);

  phase_t           ph  [NREG];
  logic [LAT_W-1:0] cnt [NREG];
  logic             ldf [NREG];

  logic [LAT_W-1:0] ex_cnt_q, ex_cnt_d;
  logic [LAT_W-1:0] lat_eff;
  logic             issue, wr_issue;
  logic             h_a, h_b, waw;

  function automatic logic src_hazard(input phase_t p, input logic [LAT_W-1:0] c, input logic ld);
    if (p == PH_IDLE) return 1'b0;
    if (FWD_EN == 0) return 1'b1;
    return (p == PH_EXEC) || ((p == PH_POST) && ld && (c < LAT_W'(LOAD_STAGE)));
  endfunction

  function automatic logic [SEL_W-1:0] fwd_code(input phase_t p, input logic [LAT_W-1:0] c,
                                                input logic h);
    fwd_code = SEL_W'(FWD_REGFILE);
    if ((FWD_EN != 0) && (p == PH_POST) && !h) fwd_code = c[SEL_W-1:0];
  endfunction

  // x0 has no entry; its slot reads as permanently idle.
  assign ph[0]  = PH_IDLE;
  assign cnt[0] = '0;
  assign ldf[0] = 1'b0;

  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0) lat_eff = LAT_W'(1);
    else if (id_lat > LAT_W'(MAX_LAT)) lat_eff = LAT_W'(MAX_LAT);
  end

  assign issue    = enable & id_valid & ~id_flush & ~stall;
  assign wr_issue = issue & id_reg_write & (id_rd != '0);

  for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
    sb_entry #(.POST_STAGES(POST_STAGES)) u_entry (
      .clk       (clk),
      .arst_n    (arst_n),
      .enable    (enable),
      .load      (wr_issue && (id_rd == REG_AW'(gi))),
      .lat       (lat_eff),
      .is_load_in(id_is_load),
      .phase     (ph[gi]),
      .cnt       (cnt[gi]),
      .is_load   (ldf[gi])
    );
  end

  // ex_cnt follows every issued op, writer or not, since EX is not pipelined.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ex_cnt_q <= '0;
    else         ex_cnt_q <= ex_cnt_d;
  end

  always_comb begin
    ex_cnt_d = ex_cnt_q;
    if (enable) begin
      if (issue)                 ex_cnt_d = lat_eff;
      else if (ex_cnt_q != '0)   ex_cnt_d = ex_cnt_q - LAT_W'(1);
    end
  end

  always_comb begin
    h_a       = src_hazard(ph[id_rs1], cnt[id_rs1], ldf[id_rs1]);
    h_b       = src_hazard(ph[id_rs2], cnt[id_rs2], ldf[id_rs2]);
    waw       = id_reg_write && (id_rd != '0) && (ph[id_rd] == PH_EXEC);
    ex_busy   = ex_cnt_q > LAT_W'(1);
    stall     = id_valid && !id_flush && (ex_busy || h_a || h_b || waw);
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    if (id_valid) begin
      fwd_sel_a = fwd_code(ph[id_rs1], cnt[id_rs1], h_a);
      fwd_sel_b = fwd_code(ph[id_rs2], cnt[id_rs2], h_b);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (forwarding and non-forwarding builds).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       enable, id_valid, id_flush, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_lat;
  logic       stall, ex_busy, stall_nf, ex_busy_nf;
  logic [1:0] fwd_sel_a, fwd_sel_b, fwd_sel_a_nf, fwd_sel_b_nf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_lat(id_lat), .stall(stall), .ex_busy(ex_busy),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
  );

  hazard_scoreboard #(.FWD_EN(0)) dut_nf (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_lat(id_lat), .stall(stall_nf), .ex_busy(ex_busy_nf),
    .fwd_sel_a(fwd_sel_a_nf), .fwd_sel_b(fwd_sel_b_nf)
  );

  typedef struct {
    bit       en, v, fl, wr, ld;
    bit [4:0] rs1, rs2, rd;
    bit [3:0] lat;
    bit       e_stall, e_busy;
    bit [1:0] e_sa, e_sb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit v, bit fl, int rs1, int rs2, int rd, bit wr, bit ld,
                              int lat, bit st, bit bz, int sa, int sb);
    vec_t r;
    r.en = en; r.v = v; r.fl = fl; r.wr = wr; r.ld = ld;
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd); r.lat = 4'(lat);
    r.e_stall = st; r.e_busy = bz; r.e_sa = 2'(sa); r.e_sb = 2'(sb);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enable = v.en; id_valid = v.v; id_flush = v.fl; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_rd = v.rd; id_reg_write = v.wr; id_is_load = v.ld; id_lat = v.lat;
  endtask

  // Entered just after a rising edge; checks on the falling edge, returns just after the next rise.
  task automatic apply_vec(input vec_t v, input string tag, input bit use_nf);
    drive(v);
    @(negedge clk);
    if (use_nf) begin
      chk({tag, " stall"}, int'(stall_nf), int'(v.e_stall));
      chk({tag, " ex_busy"}, int'(ex_busy_nf), int'(v.e_busy));
      chk({tag, " fwd_a"}, int'(fwd_sel_a_nf), int'(v.e_sa));
      chk({tag, " fwd_b"}, int'(fwd_sel_b_nf), int'(v.e_sb));
    end else begin
      chk({tag, " stall"}, int'(stall), int'(v.e_stall));
      chk({tag, " ex_busy"}, int'(ex_busy), int'(v.e_busy));
      chk({tag, " fwd_a"}, int'(fwd_sel_a), int'(v.e_sa));
      chk({tag, " fwd_b"}, int'(fwd_sel_b), int'(v.e_sb));
    end
    $display("%s: stall=%0d busy=%0d sel_a=%0d sel_b=%0d", tag,
             use_nf ? stall_nf : stall, use_nf ? ex_busy_nf : ex_busy,
             use_nf ? fwd_sel_a_nf : fwd_sel_a, use_nf ? fwd_sel_b_nf : fwd_sel_b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    arst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               en v fl rs1 rs2 rd wr ld lat  st bz sa sb
    tbl.push_back(mk(1, 0, 0,  5,  6, 0, 0, 0, 1,  0, 0, 0, 0)); // reset state
    tbl.push_back(mk(1, 1, 0,  1,  2, 5, 1, 0, 1,  0, 0, 0, 0)); // add x5
    tbl.push_back(mk(1, 1, 0,  5,  0, 9, 1, 0, 1,  1, 0, 0, 0)); // sub x9<-x5, x5 in EX
    tbl.push_back(mk(1, 1, 0,  5,  0, 9, 1, 0, 1,  0, 0, 1, 0)); // x5 in post 1
    tbl.push_back(mk(1, 1, 0,  9,  5, 10, 0, 0, 1, 1, 0, 0, 2)); // x9 in EX, x5 post 2
    tbl.push_back(mk(1, 1, 0,  9,  5, 10, 0, 0, 1, 0, 0, 1, 0)); // x5 committed
    tbl.push_back(mk(1, 1, 0,  9,  0, 6, 1, 1, 1,  0, 0, 2, 0)); // ld x6
    tbl.push_back(mk(1, 1, 0,  1,  6, 11, 1, 0, 1, 1, 0, 0, 0)); // load in EX
    tbl.push_back(mk(1, 1, 0,  1,  6, 11, 1, 0, 1, 1, 0, 0, 0)); // load post 1: not ready
    tbl.push_back(mk(1, 1, 0,  1,  6, 11, 1, 0, 1, 0, 0, 0, 2)); // load post 2: forward
    tbl.push_back(mk(1, 1, 0,  1,  2, 7, 1, 0, 4,  0, 0, 0, 0)); // mul x7 lat 4
    tbl.push_back(mk(1, 1, 0,  1,  2, 12, 1, 0, 1, 1, 1, 0, 0)); // independent add
    tbl.push_back(mk(1, 1, 0,  1,  2, 12, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0,  1,  2, 12, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0,  1,  2, 12, 1, 0, 1, 0, 0, 0, 0)); // EX frees up
    tbl.push_back(mk(1, 1, 0,  7,  1, 0, 0, 0, 1,  0, 0, 1, 0)); // reader of x7
    tbl.push_back(mk(1, 1, 0, 12,  7, 0, 1, 0, 1,  0, 0, 1, 2)); // add rd=x0
    tbl.push_back(mk(1, 1, 0,  0,  0, 13, 1, 0, 1, 0, 0, 0, 0)); // x0 reader, writes x13
    tbl.push_back(mk(1, 1, 0,  0,  0, 13, 1, 0, 2, 1, 0, 0, 0)); // WAW on x13 in EX
    tbl.push_back(mk(1, 1, 0,  0,  0, 13, 1, 0, 2, 0, 0, 0, 0)); // x13 in post: reissue
    tbl.push_back(mk(1, 1, 1, 13,  0, 13, 1, 0, 3, 0, 1, 0, 0)); // flushed: no stall/issue
    tbl.push_back(mk(1, 1, 0, 13,  0, 0, 0, 0, 1,  1, 0, 0, 0)); // x13 still EX (lat 2)
    tbl.push_back(mk(1, 0, 0, 13,  0, 0, 0, 0, 1,  0, 0, 0, 0)); // no valid: outputs quiet
    tbl.push_back(mk(1, 1, 0, 13,  0, 13, 1, 0, 1, 0, 0, 2, 0)); // issue on committing rd
    tbl.push_back(mk(1, 1, 0, 13,  0, 0, 0, 0, 1,  1, 0, 0, 0)); // issue won: x13 in EX
    tbl.push_back(mk(1, 1, 0, 13,  0, 0, 0, 0, 1,  0, 0, 1, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Reset asserted while a multi-cycle op is in EX.
    do_reset();
    apply_vec(mk(1, 1, 0, 0, 0, 5, 1, 0, 3, 0, 0, 0, 0), "rst_issue", 1'b0);
    apply_vec(mk(1, 1, 0, 5, 0, 0, 0, 0, 1, 1, 1, 0, 0), "rst_pre", 1'b0);
    drive(mk(1, 1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    #1 arst_n = 1'b0;
    #1;
    chk("rst_async stall", int'(stall), 0);
    chk("rst_async ex_busy", int'(ex_busy), 0);
    chk("rst_async fwd_a", int'(fwd_sel_a), 0);
    $display("rst_async: stall=%0d busy=%0d sel_a=%0d", stall, ex_busy, fwd_sel_a);
    @(posedge clk);
    #1 arst_n = 1'b1;
    apply_vec(mk(1, 1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rst_post", 1'b0);

    // Freeze with x7 in EXEC cnt=2.
    do_reset();
    apply_vec(mk(1, 1, 0, 0, 0, 7, 1, 0, 3, 0, 0, 0, 0), "frz_issue", 1'b0);
    apply_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), "frz_step", 1'b0);
    for (int i = 0; i < 5; i++)
      apply_vec(mk(0, 1, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0, 0), $sformatf("frz_hold%0d", i), 1'b0);
    apply_vec(mk(1, 1, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0, 0), "frz_run0", 1'b0);
    apply_vec(mk(1, 1, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0), "frz_run1", 1'b0);
    apply_vec(mk(1, 1, 0, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0), "frz_run2", 1'b0);

    // Load-use without forwarding: wait for commit, then read the regfile.
    do_reset();
    apply_vec(mk(1, 1, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 0), "nf_ld", 1'b1);
    for (int i = 0; i < 3; i++)
      apply_vec(mk(1, 1, 0, 1, 6, 11, 1, 0, 1, 1, 0, 0, 0), $sformatf("nf_wait%0d", i), 1'b1);
    apply_vec(mk(1, 1, 0, 1, 6, 11, 1, 0, 1, 0, 0, 0, 0), "nf_go", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
